// File: rtl/cam_store_responder_if.sv
// ---------------------------------------------------------------------------
// cam_store_responder_if
// Bundles the write-request and readback signals exchanged between the CAM
// data-store sequencer (master) and the bank-side responder (slave).
//   chip_enable  : one-hot bank select, nonzero = request (master -> slave)
//   cmp_addr_reg : entry address of the write                (master -> slave)
//   data_in      : per-bank write vector                     (master -> slave)
//   write_ack    : one-cycle commit pulse                    (slave -> master)
//   busy         : responder not in IDLE                     (slave -> master)
//   err_multi    : sticky multi-hot request flag             (slave -> master)
//   rd_en/rd_addr: readback strobe and entry address         (master -> slave)
//   rd_data      : whole-vector readback, rd_valid qualifies (slave -> master)
//   wr_count     : saturating count of completed writes      (slave -> master)
// ---------------------------------------------------------------------------
interface cam_store_responder_if #(
   parameter int NUM_BANKS = 16,
   parameter int ADDR_W    = 10
);
   logic [NUM_BANKS-1:0] chip_enable;
   logic [ADDR_W-1:0]    cmp_addr_reg;
   logic [NUM_BANKS-1:0] data_in;
   logic                 write_ack;
   logic                 busy;
   logic                 err_multi;
   logic                 rd_en;
   logic [ADDR_W-1:0]    rd_addr;
   logic [NUM_BANKS-1:0] rd_data;
   logic                 rd_valid;
   logic [15:0]          wr_count;

   modport master (
      output chip_enable, cmp_addr_reg, data_in, rd_en, rd_addr,
      input  write_ack, busy, err_multi, rd_data, rd_valid, wr_count
   );

   modport slave (
      input  chip_enable, cmp_addr_reg, data_in, rd_en, rd_addr,
      output write_ack, busy, err_multi, rd_data, rd_valid, wr_count
   );
endinterface

// File: rtl/cam_store_responder.sv
// ---------------------------------------------------------------------------
// cam_store_responder
// Bank-side target of the CAM vector store path. NUM_BANKS single-bit banks of
// 2^ADDR_W entries. A one-hot request writes data_in[bank] into the selected
// bank at cmp_addr_reg and answers with a one-cycle write_ack WR_LAT cycles
// after acceptance. A held request is acknowledged once only (HOLD state).
// Ports:
//   CLK  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cam_store_responder_if slave modport (request, ack, status,
//          readback)
// ---------------------------------------------------------------------------
module cam_store_responder #(
   parameter int NUM_BANKS = 16,
   parameter int ADDR_W    = 10,
   parameter int WR_LAT    = 3
) (
   input  logic                   CLK,
   input  logic                   rst,
   cam_store_responder_if.slave   bus
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [3:0] LAT_INIT = 4'(WR_LAT - 1);
   localparam logic       LAT_ONE  = (WR_LAT == 1);
   localparam logic [NUM_BANKS-1:0] VEC_ONE = NUM_BANKS'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   // True when exactly one bit of v is set.
   function automatic logic f_is_onehot(input logic [NUM_BANKS-1:0] v);
      return (v != '0) && ((v & (v - VEC_ONE)) == '0);
   endfunction

   // Index of the set bit of a one-hot vector.
   function automatic logic [BANK_W-1:0] f_bank_idx(input logic [NUM_BANKS-1:0] v);
      logic [BANK_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (v[i]) begin
            idx = BANK_W'(i);
         end
      end
      return idx;
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
   endfunction

   state_t               r_state;
   logic [3:0]           r_cnt;
   logic [BANK_W-1:0]    r_bank;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_bit;
   logic [NUM_BANKS-1:0] r_ce_lat;
   logic                 r_write_ack;
   logic                 r_busy;
   logic                 r_err_multi;
   logic [15:0]          r_wr_count;
   logic [NUM_BANKS-1:0] r_rd_data;
   logic                 r_rd_valid;
   logic [NUM_BANKS-1:0] r_mem [DEPTH];

   logic                 w_onehot;
   logic                 w_multi;
   logic [BANK_W-1:0]    w_in_bank;
   logic                 w_commit;
   logic [BANK_W-1:0]    w_cm_bank;
   logic [ADDR_W-1:0]    w_cm_addr;
   logic                 w_cm_bit;

   // Request decode and selection of the bit/location committed on this edge.
   always_comb begin
      w_onehot  = f_is_onehot(bus.chip_enable);
      w_multi   = (bus.chip_enable != '0) && !w_onehot;
      w_in_bank = f_bank_idx(bus.chip_enable);
      w_commit  = 1'b0;
      w_cm_bank = r_bank;
      w_cm_addr = r_addr;
      w_cm_bit  = r_bit;
      if (rst) begin
         w_commit = 1'b0;
      end else if (LAT_ONE && (r_state == S_IDLE) && w_onehot) begin
         // Single-cycle latency: commit straight from the live request.
         w_commit  = 1'b1;
         w_cm_bank = w_in_bank;
         w_cm_addr = bus.cmp_addr_reg;
         w_cm_bit  = bus.data_in[w_in_bank];
      end else if ((r_state == S_WAIT) && (r_cnt == 4'd1)) begin
         w_commit = 1'b1;
      end else begin
         w_commit = 1'b0;
      end
   end

   // Request FSM with registered ack/busy/error/count outputs.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_bank      <= '0;
         r_addr      <= '0;
         r_bit       <= 1'b0;
         r_ce_lat    <= '0;
         r_write_ack <= 1'b0;
         r_busy      <= 1'b0;
         r_err_multi <= 1'b0;
         r_wr_count  <= 16'd0;
      end else begin
         r_write_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_onehot) begin
                  r_bank   <= w_in_bank;
                  r_addr   <= bus.cmp_addr_reg;
                  r_bit    <= bus.data_in[w_in_bank];
                  r_ce_lat <= bus.chip_enable;
                  r_busy   <= 1'b1;
                  if (LAT_ONE) begin
                     r_state     <= S_ACK;
                     r_cnt       <= 4'd0;
                     r_write_ack <= 1'b1;
                     r_wr_count  <= f_sat_inc(r_wr_count);
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= LAT_INIT;
                  end
               end else if (w_multi) begin
                  r_err_multi <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd1) begin
                  r_state     <= S_ACK;
                  r_cnt       <= 4'd0;
                  r_write_ack <= 1'b1;
                  r_wr_count  <= f_sat_inc(r_wr_count);
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_ACK: begin
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               // Any change away from the acknowledged request ends the hold;
               // a new nonzero value is then evaluated from IDLE.
               if (bus.chip_enable == r_ce_lat) begin
                  r_state <= S_HOLD;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Bank storage: no reset, written only on the commit edge.
   always_ff @(posedge CLK) begin
      if (w_commit) begin
         r_mem[w_cm_addr][w_cm_bank] <= w_cm_bit;
      end
   end

   // Readback: samples storage before the same-edge commit lands.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            r_rd_data <= r_mem[bus.rd_addr];
         end
      end
   end

   assign bus.write_ack = r_write_ack;
   assign bus.busy      = r_busy;
   assign bus.err_multi = r_err_multi;
   assign bus.wr_count  = r_wr_count;
   assign bus.rd_data   = r_rd_data;
   assign bus.rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_cam_store_responder.sv
// ---------------------------------------------------------------------------
// tb_cam_store_responder
// Directed bench for cam_store_responder: a WR_LAT=3 instance driven by a
// cycle table plus hand sequences, and a WR_LAT=1 instance for the
// read/write collision case.
// ---------------------------------------------------------------------------
module tb_cam_store_responder;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cam_store_responder_if #(.NUM_BANKS(16), .ADDR_W(10)) bus3 ();
   cam_store_responder_if #(.NUM_BANKS(16), .ADDR_W(10)) bus1 ();

   cam_store_responder #(.NUM_BANKS(16), .ADDR_W(10), .WR_LAT(3)) u_dut3 (
      .CLK (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   cam_store_responder #(.NUM_BANKS(16), .ADDR_W(10), .WR_LAT(1)) u_dut1 (
      .CLK (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ce;
      logic [9:0]  addr;
      logic [15:0] din;
      logic        rd_en;
      logic [9:0]  rd_addr;
      logic        ack;
      logic        busy;
      logic        err;
      logic        rvalid;
      logic [15:0] rmask;
      logic [15:0] rdata;
      logic [15:0] wcnt;
   } vec_t;

   vec_t tbl [17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic read3(input logic [9:0] a, output logic [15:0] d, output logic v);
      bus3.rd_en   = 1'b1;
      bus3.rd_addr = a;
      tick();
      d = bus3.rd_data;
      v = bus3.rd_valid;
      bus3.rd_en = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      logic        rv;
      int          lat;
      int          acks;
      int          extra;
      int          first_pos;

      n_checks = 0;
      n_errors = 0;

      //       ce        addr     din       rd rd_addr  ack  busy err  rv   rmask     rdata     wcnt
      tbl[0]  = '{16'h0004, 10'h021, 16'hE26F, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd0};
      tbl[1]  = '{16'h0004, 10'h021, 16'hE26F, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd0};
      tbl[2]  = '{16'h0004, 10'h021, 16'hE26F, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[3]  = '{16'h0004, 10'h021, 16'hE26F, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[4]  = '{16'h0004, 10'h021, 16'hE26F, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[5]  = '{16'h0000, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[6]  = '{16'h0000, 10'h000, 16'h0000, 1'b1, 10'h021, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0004, 16'd1};
      tbl[7]  = '{16'h0000, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0004, 16'd1};
      tbl[8]  = '{16'h0003, 10'h021, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[9]  = '{16'h0000, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[10] = '{16'h0000, 10'h000, 16'h0000, 1'b1, 10'h021, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 16'h0004, 16'd1};
      tbl[11] = '{16'h0001, 10'h030, 16'h0001, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[12] = '{16'h0001, 10'h030, 16'h0001, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd1};
      tbl[13] = '{16'h0001, 10'h030, 16'h0001, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd2};
      tbl[14] = '{16'h0000, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd2};
      tbl[15] = '{16'h0000, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd2};
      tbl[16] = '{16'h0000, 10'h000, 16'h0000, 1'b1, 10'h030, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0001, 16'd2};

      bus3.chip_enable = 16'h0000; bus3.cmp_addr_reg = 10'h000; bus3.data_in = 16'h0000;
      bus3.rd_en = 1'b0; bus3.rd_addr = 10'h000;
      bus1.chip_enable = 16'h0000; bus1.cmp_addr_reg = 10'h000; bus1.data_in = 16'h0000;
      bus1.rd_en = 1'b0; bus1.rd_addr = 10'h000;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_ack",    32'(bus3.write_ack), 32'd0);
      chk("rst_busy",   32'(bus3.busy),      32'd0);
      chk("rst_err",    32'(bus3.err_multi), 32'd0);
      chk("rst_rvalid", 32'(bus3.rd_valid),  32'd0);
      chk("rst_rdata",  32'(bus3.rd_data),   32'd0);
      chk("rst_wcnt",   32'(bus3.wr_count),  32'd0);
      chk("rst1_busy",  32'(bus1.busy),      32'd0);
      rst = 1'b0;

      // Single write, readback, multi-hot, follow-up valid write
      for (int i = 0; i < 17; i++) begin
         bus3.chip_enable  = tbl[i].ce;
         bus3.cmp_addr_reg = tbl[i].addr;
         bus3.data_in      = tbl[i].din;
         bus3.rd_en        = tbl[i].rd_en;
         bus3.rd_addr      = tbl[i].rd_addr;
         tick();
         chk($sformatf("tbl%0d_ack", i),    32'(bus3.write_ack), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d_busy", i),   32'(bus3.busy),      32'(tbl[i].busy));
         chk($sformatf("tbl%0d_err", i),    32'(bus3.err_multi), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_rvalid", i), 32'(bus3.rd_valid),  32'(tbl[i].rvalid));
         chk($sformatf("tbl%0d_rdata", i),  32'(bus3.rd_data & tbl[i].rmask), 32'(tbl[i].rdata));
         chk($sformatf("tbl%0d_wcnt", i),   32'(bus3.wr_count),  32'(tbl[i].wcnt));
      end
      bus3.rd_en = 1'b0;

      // Full vector sweep over all banks at 0x022
      acks  = 0;
      extra = 0;
      for (int b = 0; b < 16; b++) begin
         bus3.chip_enable  = 16'h0001 << b;
         bus3.cmp_addr_reg = 10'h022;
         bus3.data_in      = 16'hF89B;
         lat = 0;
         for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus3.write_ack) begin
               lat = c;
               break;
            end
         end
         chk($sformatf("sweep%0d_lat", b), 32'(lat), 32'd3);
         if (lat != 0) acks++;
         tick();
         if (bus3.write_ack) extra++;
         bus3.chip_enable = 16'h0000;
         tick();
         if (bus3.write_ack) extra++;
         tick();
         if (bus3.write_ack) extra++;
      end
      chk("sweep_acks",  32'(acks),  32'd16);
      chk("sweep_extra", 32'(extra), 32'd0);
      chk("sweep_wcnt",  32'(bus3.wr_count), 32'd18);
      read3(10'h022, rd, rv);
      chk("sweep_rvalid", 32'(rv), 32'd1);
      chk("sweep_rdata",  32'(rd), 32'h0000F89B);

      // Back-to-back: switch request on the ack cycle
      bus3.chip_enable  = 16'h0001;
      bus3.cmp_addr_reg = 10'h040;
      bus3.data_in      = 16'hFFFF;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (bus3.write_ack) begin
            lat = c;
            break;
         end
      end
      chk("b2b_first_lat", 32'(lat), 32'd3);
      bus3.chip_enable  = 16'h0002;
      bus3.cmp_addr_reg = 10'h041;
      bus3.data_in      = 16'h0002;
      acks = 0;
      first_pos = 0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (bus3.write_ack) begin
            acks++;
            if (first_pos == 0) first_pos = t;
         end
      end
      chk("b2b_acks", 32'(acks), 32'd1);
      chk("b2b_pos",  32'(first_pos), 32'd5);
      bus3.chip_enable = 16'h0000;
      tick();
      tick();
      chk("b2b_wcnt", 32'(bus3.wr_count), 32'd20);
      read3(10'h040, rd, rv);
      chk("b2b_rd40", 32'(rd & 16'h0001), 32'h1);
      read3(10'h041, rd, rv);
      chk("b2b_rd41", 32'(rd & 16'h0002), 32'h2);

      // Reset one cycle after acceptance: discard request
      bus3.chip_enable  = 16'h0020;
      bus3.cmp_addr_reg = 10'h022;
      bus3.data_in      = 16'hFFFF;
      tick();
      chk("rstw_busy_pre", 32'(bus3.busy), 32'd1);
      rst = 1'b1;
      bus3.chip_enable = 16'h0000;
      tick();
      rst = 1'b0;
      chk("rstw_ack",    32'(bus3.write_ack), 32'd0);
      chk("rstw_busy",   32'(bus3.busy),      32'd0);
      chk("rstw_err",    32'(bus3.err_multi), 32'd0);
      chk("rstw_wcnt",   32'(bus3.wr_count),  32'd0);
      chk("rstw_rvalid", 32'(bus3.rd_valid),  32'd0);
      chk("rstw_rdata",  32'(bus3.rd_data),   32'd0);
      acks = 0;
      for (int t = 0; t < 5; t++) begin
         tick();
         if (bus3.write_ack) acks++;
      end
      chk("rstw_noack", 32'(acks), 32'd0);
      read3(10'h022, rd, rv);
      chk("rstw_keep", 32'(rd), 32'h0000F89B);

      // WR_LAT=1: latency and read-before-write collision
      bus1.chip_enable  = 16'h0001;
      bus1.cmp_addr_reg = 10'h010;
      bus1.data_in      = 16'h0000;
      tick();
      chk("l1_ack",  32'(bus1.write_ack), 32'd1);
      tick();
      chk("l1_hold_noack", 32'(bus1.write_ack), 32'd0);
      bus1.chip_enable = 16'h0000;
      tick();
      bus1.chip_enable  = 16'h0001;
      bus1.data_in      = 16'h0001;
      bus1.rd_en        = 1'b1;
      bus1.rd_addr      = 10'h010;
      tick();
      chk("col_ack",    32'(bus1.write_ack), 32'd1);
      chk("col_rvalid", 32'(bus1.rd_valid), 32'd1);
      chk("col_old",    32'(bus1.rd_data & 16'h0001), 32'h0);
      tick();
      chk("col_new",    32'(bus1.rd_data & 16'h0001), 32'h1);
      bus1.chip_enable = 16'h0000;
      bus1.rd_en       = 1'b0;
      tick();
      chk("l1_wcnt",  32'(bus1.wr_count), 32'd2);
      chk("l1_rvoff", 32'(bus1.rd_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cam_store_responder.md
Name: cam_store_responder

Overview:
- Bank-side responder for the CAM vector store path: the target of the one-hot `chip_enable` / `cmp_addr_reg` / `data_in` write requests issued by the CAM data-store sequencer.
- Holds NUM_BANKS single-bit-wide banks of 2^ADDR_W entries.
- Commits the selected bank's bit and returns a one-cycle `write_ack` after a fixed latency.
- Provides a whole-vector readback port for the compare/verify path.

Parameters:
- NUM_BANKS, 16, number of banks; equals `chip_enable` and `data_in` width.
- ADDR_W, 10, entry address width; depth = 2^ADDR_W.
- WR_LAT, 3, cycles from request acceptance to `write_ack`; legal range 1..15.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- chip_enable  in  NUM_BANKS  one-hot bank select; nonzero means request; held by requester until ack.
- cmp_addr_reg  in  ADDR_W  entry address of the write.
- data_in  in  NUM_BANKS  vector; bank i stores `data_in[i]`.
- write_ack  out  1  one-cycle pulse, write committed.
- busy  out  1  high in any state other than IDLE.
- err_multi  out  1  sticky: a request with more than one `chip_enable` bit set was seen.
- rd_en  in  1  readback strobe.
- rd_addr  in  ADDR_W  readback entry address.
- rd_data  out  NUM_BANKS  bit i = bank i at `rd_addr`.
- rd_valid  out  1  `rd_data` valid, one cycle after `rd_en`.
- wr_count  out  16  completed writes, saturates at 0xFFFF.

Behaviour:
- Reset values: `write_ack`=0, `busy`=0, `err_multi`=0, `rd_data`=0, `rd_valid`=0, `wr_count`=0, FSM=IDLE, latency counter=0. Bank storage is not reset.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - If `chip_enable` is exactly one-hot: latch bank index, `cmp_addr_reg` and `data_in[bank]`. Go to WAIT with counter=WR_LAT-1, or go directly to ACK if WR_LAT=1.
  - If `chip_enable` has two or more bits set: set `err_multi`, stay in IDLE, no write, no ack.
  - If `chip_enable` is zero: stay in IDLE.
- WAIT: decrement counter each cycle; when counter reaches 1, go to ACK.
- ACK:
  - `write_ack`=1 for exactly this cycle.
  - The latched bit is written to the latched bank/address on the edge entering ACK.
  - `wr_count` increments (saturating).
  - Next state is HOLD.
- HOLD:
  - Stay while `chip_enable` equals the latched one-hot value, so a held request is never accepted twice.
  - When `chip_enable` is zero, go to IDLE.
  - When `chip_enable` changes to a different nonzero value, go to IDLE; that value is evaluated in the following cycle.
- Latency: request sampled at edge T gives `write_ack` high during cycle T+WR_LAT.
- Changes to `chip_enable`, `cmp_addr_reg` or `data_in` during WAIT or ACK are ignored; only latched values are written.
- Readback:
  - `rd_en` sampled at edge T gives `rd_data` and `rd_valid`=1 in cycle T+1.
  - `rd_valid` is 0 otherwise; `rd_data` holds its last value.
  - Readback is independent of the FSM and is allowed in any state.
- Read/write collision: a read of the same address on the edge that commits the write returns the old data (read-before-write).
- Reset mid-operation: any latched request is discarded with no write and no ack. Storage keeps prior contents. The requester must re-issue.
- `err_multi` clears only on `rst`.
- Address arithmetic: no wrap logic needed; `cmp_addr_reg` directly indexes 0..2^ADDR_W-1.

Test Plan:
- Single write, WR_LAT=3: `chip_enable`=0x0004, `cmp_addr_reg`=0x021, `data_in`=0xE26F (bit2=1), held → `write_ack` pulses 3 cycles after acceptance, exactly once while held. `rd_addr`=0x021 then gives `rd_data` bit2=1, `rd_valid` one cycle after `rd_en`. `wr_count`=1.
- Full vector sweep: 16 requests, bank 0..15, addr 0x022, `data_in`=0xF89B, each held until ack then dropped for 2 cycles → 16 acks, `wr_count`=16, readback of 0x022 = 0xF89B.
- Multi-hot: `chip_enable`=0x0003 → `err_multi`=1, no `write_ack`, `busy`=0, storage unchanged. Subsequent valid 0x0001 write still acks.
- Back-to-back without gap: `chip_enable` switches from 0x0001 to 0x0002 on the ack cycle → HOLD exits, second request is accepted and acked; no double ack for 0x0001.
- Reset mid-WAIT: assert `rst` one cycle after acceptance → no ack, outputs at reset values, target entry keeps its old value on readback.
- WR_LAT=1 build plus collision: ack in the cycle after acceptance; a read of the same address on the commit edge returns the old value, and the next read returns the new value.
